// File: rtl/vpipe_pkg.sv
// Shared defaults and the pipeline stage record for the vpipe forwarding pipeline.
package vpipe_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_EX_DEPTH = 1;
  localparam int DEF_TAG_W    = 4;

  // One pipeline slot: occupancy, instruction tag and the value it carries.
  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/vpipe_stage.sv
// One stall-able pipeline slot (valid/tag/data) with synchronous clear on rst.
module vpipe_stage
  import vpipe_pkg::*;
#(
  parameter type rec_t = stage_t
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  rec_t d_i,
  output rec_t q_o
);

  rec_t slot_q;

  // NOTE: state is updated with non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (!stall) begin
      slot_q <= d_i;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/vpipe_fwd_pipe.sv
// ID -> EX[1..EX_DEPTH] -> WB pipeline computing reg = reg*2+1 per instruction.
// Define VPIPE_FWD_EN to forward EX results into ID; otherwise issue waits for an empty pipe.
module vpipe_fwd_pipe
  import vpipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int EX_DEPTH = DEF_EX_DEPTH,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] reg_init,
  input  logic             stall,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  output logic [WIDTH-1:0] reg_q,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } rec_t;

  // Slot 0 is ID, slot k is EX[k].
  rec_t stg_d [EX_DEPTH+1];
  rec_t stg_q [EX_DEPTH+1];

  logic [WIDTH-1:0] operand;
  logic             wb_valid_q;
  logic             id_data_unused;

  for (genvar k = 0; k <= EX_DEPTH; k++) begin : g_stage
    vpipe_stage #(.rec_t(rec_t)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .d_i   (stg_d[k]),
      .q_o   (stg_q[k])
    );
  end

  // ID carries no data of its own; its operand is read combinationally.
  assign id_data_unused = ^stg_q[0].data;

`ifdef VPIPE_FWD_EN
  // The youngest valid EX slot (lowest index) holds the newest result.
  always_comb begin
    operand = reg_q;
    for (int k = EX_DEPTH; k >= 1; k--) begin
      if (stg_q[k].valid) operand = stg_q[k].data;
    end
  end

  assign issue_ready = !stall && !rst;
`else
  logic busy;

  assign operand = reg_q;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= EX_DEPTH; k++) begin
      busy = busy | stg_q[k].valid;
    end
  end

  assign issue_ready = !stall && !rst && !busy;
`endif

  always_comb begin
    // NOTE: every stage input is defaulted first so no path through this block can infer a latch.
    for (int k = 0; k <= EX_DEPTH; k++) stg_d[k] = '0;
    stg_d[0].valid = issue_valid && issue_ready;
    stg_d[0].tag   = issue_tag;
    stg_d[1].valid = stg_q[0].valid;
    stg_d[1].tag   = stg_q[0].tag;
    stg_d[1].data  = {operand[WIDTH-2:0], 1'b1};
    for (int k = 2; k <= EX_DEPTH; k++) stg_d[k] = stg_q[k-1];
  end

  // A write that lands just before a stall stays pending and is reported once the stall lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q      <= reg_init;
      wb_valid_q <= 1'b0;
      wb_tag     <= '0;
    end else if (!stall) begin
      wb_valid_q <= stg_q[EX_DEPTH].valid;
      if (stg_q[EX_DEPTH].valid) begin
        reg_q  <= stg_q[EX_DEPTH].data;
        wb_tag <= stg_q[EX_DEPTH].tag;
      end
    end
  end

  assign wb_valid = wb_valid_q && !stall;

endmodule

// File: tb/tb_vpipe_fwd_pipe.sv
// Self-checking bench for vpipe_fwd_pipe: directed tables, a deep-pipe sequence and a randomized model run.
module tb_vpipe_fwd_pipe;

`ifdef VPIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int EX_D = 1;

  logic       clk = 1'b0;
  logic       rst, stall, issue_valid, issue_ready, wb_valid;
  logic [3:0] reg_init, issue_tag, reg_q, wb_tag;

  logic       r3_rst, r3_stall, r3_valid, r3_ready, r3_wb;
  logic [3:0] r3_init, r3_tag, r3_reg, r3_wtag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vpipe_fwd_pipe #(.WIDTH(4), .EX_DEPTH(EX_D), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .reg_init(reg_init), .stall(stall),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
    .reg_q(reg_q), .wb_valid(wb_valid), .wb_tag(wb_tag)
  );

  vpipe_fwd_pipe #(.WIDTH(4), .EX_DEPTH(3), .TAG_W(4)) dut3 (
    .clk(clk), .rst(r3_rst), .reg_init(r3_init), .stall(r3_stall),
    .issue_valid(r3_valid), .issue_tag(r3_tag), .issue_ready(r3_ready),
    .reg_q(r3_reg), .wb_valid(r3_wb), .wb_tag(r3_wtag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         r, s, v;
    logic [3:0] tag, init;
    bit         e_rdy, e_wb;
    logic [3:0] e_reg, e_tag;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(bit r, bit s, bit v, int tag, int init,
                              bit e_rdy, bit e_wb, int e_reg, int e_tag);
    row_t x;
    x.r = r; x.s = s; x.v = v; x.tag = 4'(tag); x.init = 4'(init);
    x.e_rdy = e_rdy; x.e_wb = e_wb; x.e_reg = 4'(e_reg); x.e_tag = 4'(e_tag);
    return x;
  endfunction

  // Reference model: in-flight instructions in issue order, each retiring after EX_D+1 unstalled edges.
  typedef struct { logic [3:0] tag; int rem; } fl_t;
  fl_t        m_q[$];
  logic [3:0] m_reg, m_wtag;
  bit         m_wb;

  function automatic bit m_ready(bit r, bit s);
    return !r && !s && (FWD || m_q.size() == 0);
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit acc,
                            input logic [3:0] tag, input logic [3:0] init);
    fl_t n;
    if (r) begin
      m_reg = init; m_q.delete(); m_wb = 1'b0; m_wtag = 4'd0;
    end else if (!s) begin
      m_wb = 1'b0;
      foreach (m_q[i]) m_q[i].rem--;
      if (m_q.size() > 0 && m_q[0].rem == 0) begin
        m_reg  = 4'(m_reg * 2 + 1);
        m_wb   = 1'b1;
        m_wtag = m_q[0].tag;
        void'(m_q.pop_front());
      end
      if (acc) begin
        n.tag = tag; n.rem = EX_D + 1;
        m_q.push_back(n);
      end
    end
  endtask

  initial begin
    bit         rr, ss, vv, erdy;
    logic [3:0] tt, ii;

    rst = 1'b1; stall = 1'b0; issue_valid = 1'b0; issue_tag = 4'd0; reg_init = 4'd5;
    r3_rst = 1'b1; r3_stall = 1'b0; r3_valid = 1'b0; r3_tag = 4'd0; r3_init = 4'd15;

`ifdef VPIPE_FWD_EN
    tbl.push_back(mk(0,0,0,0,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,3,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,1,11,3));
    tbl.push_back(mk(1,0,0,0,5, 0,0,11,3));
    tbl.push_back(mk(0,0,1,1,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,2,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,3,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,1,11,1));
    tbl.push_back(mk(0,0,0,0,5, 1,1, 7,2));
    tbl.push_back(mk(0,0,0,0,5, 1,1,15,3));
    tbl.push_back(mk(0,0,0,0,5, 1,0,15,3));
    tbl.push_back(mk(1,0,0,0,5, 0,0,15,3));
    tbl.push_back(mk(0,0,1,4,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,5,5, 1,0, 5,0));
    tbl.push_back(mk(0,1,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,1,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,1,11,4));
    tbl.push_back(mk(0,0,0,0,5, 1,1, 7,5));
    tbl.push_back(mk(0,0,0,0,5, 1,0, 7,5));
    tbl.push_back(mk(0,0,1,6,5, 1,0, 7,5));
    tbl.push_back(mk(0,0,0,0,5, 1,0, 7,5));
    tbl.push_back(mk(1,0,0,0,9, 0,0, 7,5));
    tbl.push_back(mk(0,0,0,0,9, 1,0, 9,0));
    tbl.push_back(mk(0,0,0,0,9, 1,0, 9,0));
    tbl.push_back(mk(0,0,0,0,9, 1,0, 9,0));
`else
    tbl.push_back(mk(0,0,0,0,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,3,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,1,11,3));
    tbl.push_back(mk(1,0,0,0,5, 0,0,11,3));
    tbl.push_back(mk(0,0,1,1,5, 1,0, 5,0));
    tbl.push_back(mk(0,0,1,2,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,1,2,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,1,2,5, 1,1,11,1));
    tbl.push_back(mk(0,0,1,3,5, 0,0,11,1));
    tbl.push_back(mk(0,0,1,3,5, 0,0,11,1));
    tbl.push_back(mk(0,0,1,3,5, 1,1, 7,2));
    tbl.push_back(mk(0,0,0,0,5, 0,0, 7,2));
    tbl.push_back(mk(0,0,0,0,5, 0,0, 7,2));
    tbl.push_back(mk(0,0,0,0,5, 1,1,15,3));
    tbl.push_back(mk(1,0,0,0,5, 0,0,15,3));
    tbl.push_back(mk(0,0,1,4,5, 1,0, 5,0));
    tbl.push_back(mk(0,1,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,1,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 0,0, 5,0));
    tbl.push_back(mk(0,0,0,0,5, 1,1,11,4));
    tbl.push_back(mk(0,0,0,0,5, 1,0,11,4));
    tbl.push_back(mk(0,0,1,6,5, 1,0,11,4));
    tbl.push_back(mk(0,0,0,0,5, 0,0,11,4));
    tbl.push_back(mk(1,0,0,0,9, 0,0,11,4));
    tbl.push_back(mk(0,0,0,0,9, 1,0, 9,0));
    tbl.push_back(mk(0,0,0,0,9, 1,0, 9,0));
`endif

    repeat (2) @(posedge clk);
    #1;

    // Directed table: one row per cycle, outputs checked mid-cycle.
    foreach (tbl[i]) begin
      rst = tbl[i].r; stall = tbl[i].s; issue_valid = tbl[i].v;
      issue_tag = tbl[i].tag; reg_init = tbl[i].init;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), 32'(issue_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wb));
      check($sformatf("tbl%0d_reg_q", i), 32'(reg_q), 32'(tbl[i].e_reg));
      check($sformatf("tbl%0d_wb_tag", i), 32'(wb_tag), 32'(tbl[i].e_tag));
      @(posedge clk);
      #1;
    end

    // Deep pipe: reg_init=15, one issue, write-back five cycles after acceptance.
    r3_rst = 1'b0; r3_valid = 1'b1; r3_tag = 4'd7;
    @(negedge clk);
    check("d3_accept_ready", 32'(r3_ready), 32'd1);
    check("d3_init_reg", 32'(r3_reg), 32'd15);
    @(posedge clk);
    #1;
    r3_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check($sformatf("d3_wb_c%0d", n), 32'(r3_wb), 32'(n == 5));
      check($sformatf("d3_ready_c%0d", n), 32'(r3_ready), 32'(FWD || n == 5));
      check($sformatf("d3_reg_c%0d", n), 32'(r3_reg), 32'd15);
      check($sformatf("d3_tag_c%0d", n), 32'(r3_wtag), (n == 5) ? 32'd7 : 32'd0);
      @(posedge clk);
      #1;
    end

    // Randomized run against the model, starting from a reset cycle.
    rst = 1'b1; stall = 1'b0; issue_valid = 1'b0; reg_init = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_edge(1'b1, 1'b0, 1'b0, 4'd0, reg_init);
    #1;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      ss = ($urandom_range(0, 4) == 0);
      vv = $urandom_range(0, 1) == 1;
      tt = 4'($urandom_range(0, 15));
      ii = 4'($urandom_range(0, 15));
      rst = rr; stall = ss; issue_valid = vv; issue_tag = tt; reg_init = ii;
      erdy = m_ready(rr, ss);
      @(negedge clk);
      check("rnd_ready", 32'(issue_ready), 32'(erdy));
      check("rnd_wb_valid", 32'(wb_valid), 32'(m_wb && !ss));
      check("rnd_reg_q", 32'(reg_q), 32'(m_reg));
      check("rnd_wb_tag", 32'(wb_tag), 32'(m_wtag));
      @(posedge clk);
      model_edge(rr, ss, vv && erdy, tt, ii);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
